// File: rtl/comb_mux8_pkg.sv
// Shared definitions for the comb_mux8 eight-input data selector.
// Optional build macro: COMB_MUX8_OUT_REG_EN (adds a registered output stage).
package comb_mux8_pkg;

  // Number of selectable data inputs.
  localparam int N_IN = 8;

  // Width of the selection field.
  localparam int SEL_W = 3;

  // Inputs handled by each 4:1 half of the tree.
  localparam int HALF_N = N_IN / 2;

  // Selection code type.
  typedef logic [SEL_W-1:0] sel_t;

  // Most significant selection bit, which steers the final 2:1 stage.
  function automatic logic sel_upper(input sel_t s);
    return s[SEL_W-1];
  endfunction

endpackage

// File: rtl/comb_mux8_mux4.sv
// 4:1 combinational data selector used for each half of the comb_mux8 tree.
// Optional build macro for the parent: COMB_MUX8_OUT_REG_EN (not used here).
module comb_mux8_mux4 #(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  output logic [DATA_W-1:0] out0
);

  // Full-width index select; in0 is the default so no latch can form.
  always_comb begin
    out0 = in0;
    case (sel)
      2'd0:    out0 = in0;
      2'd1:    out0 = in1;
      2'd2:    out0 = in2;
      2'd3:    out0 = in3;
      default: out0 = in0;
    endcase
  end

endmodule

// File: rtl/comb_mux8.sv
// Eight-input, DATA_W-bit data selector for the Versat datapath.
// out0 = in[sel]. Default build is purely combinational.
// Optional build macro: COMB_MUX8_OUT_REG_EN -- adds a one-cycle output
// register after the final 2:1 stage, cleared by synchronous rst.
module comb_mux8
  import comb_mux8_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  input  sel_t              sel,
  output logic [DATA_W-1:0] out0
);

  // Inputs gathered into an indexable array so the two halves can be built
  // by one generate loop.
  logic [DATA_W-1:0] data_arr [N_IN];
  assign data_arr[0] = in0;
  assign data_arr[1] = in1;
  assign data_arr[2] = in2;
  assign data_arr[3] = in3;
  assign data_arr[4] = in4;
  assign data_arr[5] = in5;
  assign data_arr[6] = in6;
  assign data_arr[7] = in7;

  // Results of the lower (in0..in3) and upper (in4..in7) 4:1 stages.
  logic [DATA_W-1:0] half_out [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half
      comb_mux8_mux4 #(
        .DATA_W(DATA_W)
      ) u_mux4 (
        .sel  (sel[1:0]),
        .in0  (data_arr[HALF_N*gi + 0]),
        .in1  (data_arr[HALF_N*gi + 1]),
        .in2  (data_arr[HALF_N*gi + 2]),
        .in3  (data_arr[HALF_N*gi + 3]),
        .out0 (half_out[gi])
      );
    end
  endgenerate

  // Final 2:1 stage steered by the top selection bit.
  logic [DATA_W-1:0] sel_data_next;

  // Pick between the two halves; lower half is the default.
  always_comb begin
    sel_data_next = half_out[0];
    case (sel_upper(sel))
      1'b0:    sel_data_next = half_out[0];
      1'b1:    sel_data_next = half_out[1];
      default: sel_data_next = half_out[0];
    endcase
  end

`ifdef COMB_MUX8_OUT_REG_EN
  logic [DATA_W-1:0] out_reg;

  // Output register: one-cycle latency, cleared while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg <= '0;
    end else begin
      out_reg <= sel_data_next;
    end
  end

  assign out0 = out_reg;
`else
  // Combinational build: clk and rst exist only for interface uniformity
  // with other Versat units and are intentionally left unused here.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst};

  assign out0 = sel_data_next;
`endif

endmodule

// File: tb/tb_comb_mux8.sv
// Self-checking bench for comb_mux8: table-driven vectors on three widths
// (1, 8, 32) plus hand-written reset sequences. Expected values go into a
// scoreboard queue when stimulus is driven and are compared one cycle later.
module tb_comb_mux8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic        d1  [8];
  logic [7:0]  d8  [8];
  logic [31:0] d32 [8];
  logic [2:0]  s1, s8, s32;
  logic        o1;
  logic [7:0]  o8;
  logic [31:0] o32;

  comb_mux8 #(.DATA_W(1)) u_w1 (
    .clk(clk), .rst(rst),
    .in0(d1[0]), .in1(d1[1]), .in2(d1[2]), .in3(d1[3]),
    .in4(d1[4]), .in5(d1[5]), .in6(d1[6]), .in7(d1[7]),
    .sel(s1), .out0(o1)
  );

  comb_mux8 #(.DATA_W(8)) u_w8 (
    .clk(clk), .rst(rst),
    .in0(d8[0]), .in1(d8[1]), .in2(d8[2]), .in3(d8[3]),
    .in4(d8[4]), .in5(d8[5]), .in6(d8[6]), .in7(d8[7]),
    .sel(s8), .out0(o8)
  );

  comb_mux8 #(.DATA_W(32)) u_w32 (
    .clk(clk), .rst(rst),
    .in0(d32[0]), .in1(d32[1]), .in2(d32[2]), .in3(d32[3]),
    .in4(d32[4]), .in5(d32[5]), .in6(d32[6]), .in7(d32[7]),
    .sel(s32), .out0(o32)
  );

  typedef struct {
    string            name;
    int               w;
    logic [2:0]       sel;
    logic [7:0][31:0] din;
    logic [31:0]      exp;
  } vec_t;

  typedef struct {
    string       name;
    int          w;
    logic [31:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

`ifdef COMB_MUX8_OUT_REG_EN
  localparam logic [31:0] RST_EXP = 32'h0000_0000;
`else
  localparam logic [31:0] RST_EXP = 32'h0000_00A5;
`endif

  // Apply one stimulus on the falling edge and queue its expected output.
  task automatic drive(input int w, input logic [2:0] s,
                       input logic [7:0][31:0] din, input logic [31:0] exp,
                       input string name);
    sb_t item;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      case (w)
        1:       d1[k]  = din[k][0];
        8:       d8[k]  = din[k][7:0];
        default: d32[k] = din[k];
      endcase
    end
    case (w)
      1:       s1  = s;
      8:       s8  = s;
      default: s32 = s;
    endcase
    item.name = name;
    item.w    = w;
    item.exp  = exp;
    sb.push_back(item);
  endtask

  // Sample just after the next rising edge and compare with the queue head.
  task automatic check_next();
    sb_t         item;
    logic [31:0] got;
    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got no expected entry, required one");
    end else begin
      item = sb.pop_front();
      case (item.w)
        1:       got = {31'b0, o1};
        8:       got = {24'b0, o8};
        default: got = o32;
      endcase
      n_txn++;
      if (got !== item.exp) begin
        n_fail++;
        $display("FAIL %s: w=%0d out0=%h required=%h", item.name, item.w, got, item.exp);
      end else begin
        $display("txn %0d %s: w=%0d out0=%h ok", n_txn, item.name, item.w, got);
      end
    end
  endtask

  initial begin
    vec_t             v;
    logic [7:0][31:0] rv;

    for (int k = 0; k < 8; k++) begin
      d1[k] = 1'b0; d8[k] = 8'h00; d32[k] = 32'h0;
    end
    s1 = 3'd0; s8 = 3'd0; s32 = 3'd0;

    // Table: width-1 all ones and all zeros, sel swept 0..7.
    for (int k = 0; k < 8; k++) begin
      v.name = $sformatf("w1_ones_sel%0d", k);
      v.w = 1; v.sel = 3'(k);
      for (int j = 0; j < 8; j++) v.din[j] = 32'h1;
      v.exp = 32'h1;
      vecs.push_back(v);
    end
    for (int k = 0; k < 8; k++) begin
      v.name = $sformatf("w1_zeros_sel%0d", k);
      v.w = 1; v.sel = 3'(k);
      for (int j = 0; j < 8; j++) v.din[j] = 32'h0;
      v.exp = 32'h0;
      vecs.push_back(v);
    end
    // Table: width-8 distinct values per input.
    for (int k = 0; k < 8; k++) begin
      v.name = $sformatf("w8_distinct_sel%0d", k);
      v.w = 8; v.sel = 3'(k);
      for (int j = 0; j < 8; j++) v.din[j] = 32'h10 + 32'(j);
      v.exp = 32'h10 + 32'(k);
      vecs.push_back(v);
    end
    // Table: width-8 walking one with sel held at 5.
    for (int k = 0; k < 8; k++) begin
      v.name = $sformatf("w8_walk_in%0d", k);
      v.w = 8; v.sel = 3'd5;
      for (int j = 0; j < 8; j++) v.din[j] = 32'h0;
      v.din[k] = 32'h1 << k;
      v.exp = (k == 5) ? 32'h20 : 32'h0;
      vecs.push_back(v);
    end
    // Table: width-32 full-width toggling of in3, neighbours hold a pattern.
    for (int k = 0; k < 4; k++) begin
      v.name = $sformatf("w32_toggle_%0d", k);
      v.w = 32; v.sel = 3'd3;
      for (int j = 0; j < 8; j++) v.din[j] = (k < 2) ? 32'h5A5A_5A5A : 32'hA5A5_A5A5;
      v.din[3] = k[0] ? 32'h0000_0000 : 32'hFFFF_FFFF;
      v.exp    = k[0] ? 32'h0000_0000 : 32'hFFFF_FFFF;
      vecs.push_back(v);
    end

    // Reset sequence inputs: sel=2, in2=A5, other inputs carry 3C.
    for (int j = 0; j < 8; j++) rv[j] = 32'h3C;
    rv[2] = 32'hA5;

    // Reset held for two edges.
    drive(8, 3'd2, rv, RST_EXP, "rst_hold1");
    check_next();
    drive(8, 3'd2, rv, RST_EXP, "rst_hold2");
    check_next();
    // Release: data appears on the first edge with rst low.
    drive(8, 3'd2, rv, 32'hA5, "rst_release");
    rst = 1'b0;
    check_next();

    // Table-driven vectors.
    foreach (vecs[i]) begin
      drive(vecs[i].w, vecs[i].sel, vecs[i].din, vecs[i].exp, vecs[i].name);
      check_next();
    end

    // Reset asserted mid-stream, then released again.
    drive(8, 3'd2, rv, RST_EXP, "rst_midstream");
    rst = 1'b1;
    check_next();
    drive(8, 3'd2, rv, 32'hA5, "rst_rerelease");
    rst = 1'b0;
    check_next();

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
